// File: rtl/mul_div_pkg.sv
// Shared definitions for the M-extension multiply/divide datapath:
// func3 encodings, divider FSM states and width-derived constants.
package mul_div_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIXUP,
    DONE
  } div_state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference only if it is non-negative.
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  // One extra bit beyond the remainder register so the trial result's sign is exact.
  logic [WIDTH+1:0] trial;

  always_comb begin
    trial   = {rem_in, dividend_bit} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : {rem_in[WIDTH-1:0], dividend_bit};
  end

endmodule

// File: rtl/signed_div_iter_8bit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready
// handshakes; special cases (divide by zero, signed overflow) bypass iteration.
module signed_div_iter_8bit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = mul_div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_result
);

  div_state_t       state;
  logic [3:0]       count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   rem;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  logic             is_signed;
  logic             sgn1;
  logic             sgn2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic             func3_unused;

  assign func3_unused = func3[2];
  assign in_ready     = (state == IDLE);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem),
    .dividend_bit (dividend[WIDTH-1]),
    .divisor      (divisor_mag),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // Operand conditioning and special-case detection on the live inputs.
  always_comb begin
    is_signed = ~func3[0];
    sgn1      = is_signed & op1[WIDTH-1];
    sgn2      = is_signed & op2[WIDTH-1];
    mag1      = sgn1 ? -op1 : op1;
    mag2      = sgn2 ? -op2 : op2;
    special   = 1'b0;
    special_result = '0;
    if (op2 == '0) begin
      special        = 1'b1;
      special_result = func3[1] ? op1 : ALL_ONES;
    end else if (is_signed && op1 == MOST_NEG && op2 == ALL_ONES) begin
      special        = 1'b1;
      special_result = func3[1] ? '0 : MOST_NEG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dividend    <= '0;
      divisor_mag <= '0;
      quot        <= '0;
      rem         <= '0;
      is_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_valid   <= 1'b0;
      div_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_rem      <= func3[1];
            neg_q       <= sgn1 ^ sgn2;
            neg_r       <= sgn1;
            dividend    <= mag1;
            divisor_mag <= mag2;
            quot        <= '0;
            rem         <= '0;
            count       <= '0;
            if (special) begin
              div_result <= special_result;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem      <= rem_next;
          quot     <= {quot[WIDTH-2:0], q_bit};
          dividend <= dividend << 1;
          if (count == 4'd7) begin
            count <= '0;
            state <= FIXUP;
          end else begin
            count <= count + 4'd1;
          end
        end
        FIXUP: begin
          if (is_rem)
            div_result <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          else
            div_result <= neg_q ? -quot : quot;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
